// File: rtl/gb_debug_pkg.sv
// Shared types and defaults for the de10boy CPU debug unit.
package gb_debug_pkg;

    localparam int unsigned DEF_ADDR_W      = 16;
    localparam int unsigned DEF_NUM_BP      = 4;
    localparam int unsigned DEF_TRACE_DEPTH = 16;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        STEP,
        INJECT
    } dbg_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [7:0]            opcode;
    } trace_entry_t;

    // Index width that never collapses to zero for single-entry tables.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gb_debug_unit_if.sv
// Debug-unit signal bundle: master = CPU/debugger side, slave = gb_debug_unit.
interface gb_debug_unit_if
    import gb_debug_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned NUM_BP      = DEF_NUM_BP,
    parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
);
    localparam int unsigned BP_W = idx_w(NUM_BP);
    localparam int unsigned TR_W = idx_w(TRACE_DEPTH);

    logic [ADDR_W-1:0] cpu_pc;
    logic              cpu_fetch;
    logic [7:0]        cpu_opcode;
    logic              bp_wr_en;
    logic [BP_W-1:0]   bp_wr_idx;
    logic [ADDR_W-1:0] bp_wr_addr;
    logic              bp_wr_valid;
    logic              dbg_resume;
    logic              dbg_step;
    logic              dbg_pc_req;
    logic [ADDR_W-1:0] dbg_pc_val;
    logic              dbg_pc_ack;
    logic [ADDR_W-1:0] pc_new;
    logic              pc_ld;
    logic              cpu_halt;
    logic              halted;
    logic [BP_W-1:0]   hit_idx;
    logic [TR_W-1:0]   trace_rd_idx;
    logic [ADDR_W-1:0] trace_rd_pc;
    logic [7:0]        trace_rd_op;
    logic [TR_W:0]     trace_count;

    modport master (
        output cpu_pc, cpu_fetch, cpu_opcode, bp_wr_en, bp_wr_idx, bp_wr_addr,
               bp_wr_valid, dbg_resume, dbg_step, dbg_pc_req, dbg_pc_val, trace_rd_idx,
        input  dbg_pc_ack, pc_new, pc_ld, cpu_halt, halted, hit_idx,
               trace_rd_pc, trace_rd_op, trace_count
    );

    modport slave (
        input  cpu_pc, cpu_fetch, cpu_opcode, bp_wr_en, bp_wr_idx, bp_wr_addr,
               bp_wr_valid, dbg_resume, dbg_step, dbg_pc_req, dbg_pc_val, trace_rd_idx,
        output dbg_pc_ack, pc_new, pc_ld, cpu_halt, halted, hit_idx,
               trace_rd_pc, trace_rd_op, trace_count
    );

endinterface

// File: rtl/gb_trace_buffer.sv
// Circular fetch trace: write pointer, saturating fill count, newest-first indexed read.
module gb_trace_buffer
    import gb_debug_pkg::*;
#(
    parameter type         entry_t = trace_entry_t,
    parameter int unsigned DEPTH   = DEF_TRACE_DEPTH,
    localparam int unsigned PTR_W  = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  entry_t           wr_entry,
    input  logic [PTR_W-1:0] rd_idx,
    output entry_t           rd_entry,
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (count_q != FULL) count_q <= count_q + (PTR_W + 1)'(1);
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign rd_addr  = wr_ptr_q - PTR_W'(1) - rd_idx;
    assign rd_entry = ({1'b0, rd_idx} < count_q) ? mem_q[rd_addr] : '0;
    assign count    = count_q;

endmodule

// File: rtl/gb_debug_unit.sv
// CPU debug controller: PC breakpoints, halt/step/resume, handshaked PC injection, fetch trace.
module gb_debug_unit
    import gb_debug_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned NUM_BP      = DEF_NUM_BP,
    parameter int unsigned TRACE_DEPTH = DEF_TRACE_DEPTH
) (
    input  logic         Clk,
    input  logic         reset,
    gb_debug_unit_if.slave dbg
);
    localparam int unsigned BP_W = idx_w(NUM_BP);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [7:0]        opcode;
    } entry_t;

    dbg_state_t        state_q;
    logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_valid_q;
    logic              skip_q;
    logic              halted_q;
    logic              pc_ld_q;
    logic              ack_q;
    logic [ADDR_W-1:0] pc_new_q;
    logic [BP_W-1:0]   hit_idx_q;

    logic              hit_any;
    logic [BP_W-1:0]   hit_slot;
    logic              match;
    logic              halt_c;
    entry_t            wr_entry;
    entry_t            rd_entry;

    // Lowest-index valid slot wins; table is the pre-write contents.
    always_comb begin
        hit_any  = 1'b0;
        hit_slot = '0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (!hit_any && bp_valid_q[i] && bp_addr_q[i] == dbg.cpu_pc) begin
                hit_any  = 1'b1;
                hit_slot = BP_W'(i);
            end
        end
        match = dbg.cpu_fetch && hit_any && !skip_q;
    end

    always_comb begin
        halt_c = 1'b1;
        case (state_q)
            RUN:     halt_c = match;
            STEP:    halt_c = dbg.cpu_fetch;
            default: halt_c = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            bp_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
            skip_q     <= 1'b0;
            halted_q   <= 1'b0;
            pc_ld_q    <= 1'b0;
            ack_q      <= 1'b0;
            pc_new_q   <= '0;
            hit_idx_q  <= '0;
        end else begin
            pc_ld_q <= 1'b0;
            ack_q   <= 1'b0;
            if (dbg.bp_wr_en && 32'(dbg.bp_wr_idx) < NUM_BP) begin
                bp_addr_q[dbg.bp_wr_idx]  <= dbg.bp_wr_addr;
                bp_valid_q[dbg.bp_wr_idx] <= dbg.bp_wr_valid;
            end
            case (state_q)
                RUN: begin
                    if (dbg.cpu_fetch) skip_q <= 1'b0;
                    if (match) begin
                        state_q   <= HALT;
                        halted_q  <= 1'b1;
                        hit_idx_q <= hit_slot;
                    end
                end
                HALT: begin
                    if (dbg.dbg_pc_req) begin
                        state_q  <= INJECT;
                        pc_ld_q  <= 1'b1;
                        ack_q    <= 1'b1;
                        pc_new_q <= dbg.dbg_pc_val;
                    end else if (dbg.dbg_step) begin
                        state_q  <= STEP;
                        halted_q <= 1'b0;
                    end else if (dbg.dbg_resume) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                        skip_q   <= 1'b1;
                    end
                end
                STEP: begin
                    if (dbg.cpu_fetch) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                INJECT: state_q <= HALT;
            endcase
        end
    end

    assign wr_entry.pc     = dbg.cpu_pc;
    assign wr_entry.opcode = dbg.cpu_opcode;

    gb_trace_buffer #(
        .entry_t (entry_t),
        .DEPTH   (TRACE_DEPTH)
    ) u_trace (
        .clk      (Clk),
        .rst      (reset),
        .wr_en    (dbg.cpu_fetch && state_q != HALT),
        .wr_entry (wr_entry),
        .rd_idx   (dbg.trace_rd_idx),
        .rd_entry (rd_entry),
        .count    (dbg.trace_count)
    );

    assign dbg.cpu_halt    = halt_c;
    assign dbg.halted      = halted_q;
    assign dbg.pc_ld       = pc_ld_q;
    assign dbg.dbg_pc_ack  = ack_q;
    assign dbg.pc_new      = pc_new_q;
    assign dbg.hit_idx     = hit_idx_q;
    assign dbg.trace_rd_pc = rd_entry.pc;
    assign dbg.trace_rd_op = rd_entry.opcode;

endmodule

// File: tb/tb_gb_debug_unit.sv
// Testbench for gb_debug_unit: directed vector table, corner sequences, randomized model check.
module tb_gb_debug_unit;

    localparam int unsigned AW = 16;
    localparam int unsigned NB = 4;
    localparam int unsigned TD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gb_debug_unit_if #(.ADDR_W(AW), .NUM_BP(NB), .TRACE_DEPTH(TD)) bus ();
    gb_debug_unit #(.ADDR_W(AW), .NUM_BP(NB), .TRACE_DEPTH(TD)) dut (
        .Clk   (clk),
        .reset (rst),
        .dbg   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int bpw, input int bpi, input int bpa, input int bpv,
                         input int fe, input int pc, input int op,
                         input int res, input int stp, input int req, input int val);
        bus.bp_wr_en    = 1'(bpw);
        bus.bp_wr_idx   = 2'(bpi);
        bus.bp_wr_addr  = 16'(bpa);
        bus.bp_wr_valid = 1'(bpv);
        bus.cpu_fetch   = 1'(fe);
        bus.cpu_pc      = 16'(pc);
        bus.cpu_opcode  = 8'(op);
        bus.dbg_resume  = 1'(res);
        bus.dbg_step    = 1'(stp);
        bus.dbg_pc_req  = 1'(req);
        bus.dbg_pc_val  = 16'(val);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference model: debug modes and trace kept as a newest-first queue.
    typedef enum int {M_RUN, M_HALT, M_STEP, M_INJ} mmode_t;
    typedef struct { int pc; int op; } tent_t;

    mmode_t mm;
    int     m_bpa [NB];
    bit     m_bpv [NB];
    bit     m_skip;
    int     m_pcnew;
    int     m_hit;
    tent_t  m_tr [$];

    task automatic m_reset();
        mm = M_RUN;
        for (int i = 0; i < int'(NB); i++) begin
            m_bpa[i] = 0;
            m_bpv[i] = 1'b0;
        end
        m_skip  = 1'b0;
        m_pcnew = 0;
        m_hit   = 0;
        m_tr.delete();
    endtask

    function automatic int m_slot(input int pc);
        for (int i = 0; i < int'(NB); i++)
            if (m_bpv[i] && m_bpa[i] == pc) return i;
        return -1;
    endfunction

    function automatic int m_halt();
        bit hit;
        hit = bus.cpu_fetch && m_slot(int'(bus.cpu_pc)) >= 0 && !m_skip;
        case (mm)
            M_RUN:   return int'(hit);
            M_STEP:  return int'(bus.cpu_fetch);
            default: return 1;
        endcase
    endfunction

    task automatic m_commit();
        int s;
        bit fe;
        bit hit;
        s   = m_slot(int'(bus.cpu_pc));
        fe  = bus.cpu_fetch;
        hit = fe && s >= 0 && !m_skip;
        if (fe && mm != M_HALT) begin
            m_tr.push_front('{int'(bus.cpu_pc), int'(bus.cpu_opcode)});
            if (m_tr.size() > int'(TD)) void'(m_tr.pop_back());
        end
        if (bus.bp_wr_en) begin
            m_bpa[bus.bp_wr_idx] = int'(bus.bp_wr_addr);
            m_bpv[bus.bp_wr_idx] = bus.bp_wr_valid;
        end
        case (mm)
            M_RUN: begin
                if (hit) begin
                    mm    = M_HALT;
                    m_hit = s;
                end
                if (fe) m_skip = 1'b0;
            end
            M_HALT: begin
                if (bus.dbg_pc_req) begin
                    mm      = M_INJ;
                    m_pcnew = int'(bus.dbg_pc_val);
                end else if (bus.dbg_step) begin
                    mm = M_STEP;
                end else if (bus.dbg_resume) begin
                    mm     = M_RUN;
                    m_skip = 1'b1;
                end
            end
            M_STEP: if (fe) mm = M_HALT;
            M_INJ:  mm = M_HALT;
        endcase
    endtask

    typedef struct {
        int bpw, bpi, bpa, bpv, fe, pc, op, res, stp, req, val;
        int e_halt, e_halted, e_ld, e_ack, e_pcnew, e_hit, e_cnt;
    } vec_t;

    vec_t vt [$];

    initial begin
        idle();
        bus.trace_rd_idx = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst pc_ld", int'(bus.pc_ld), 0);
        chk("rst ack", int'(bus.dbg_pc_ack), 0);
        chk("rst cpu_halt", int'(bus.cpu_halt), 0);
        chk("rst halted", int'(bus.halted), 0);
        chk("rst hit_idx", int'(bus.hit_idx), 0);
        chk("rst trace_count", int'(bus.trace_count), 0);
        chk("rst pc_new", int'(bus.pc_new), 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        //            bpw bpi bpa    bpv fe pc     op    res stp req val      halt hlt ld ack pcnew  hit cnt
        vt.push_back('{1, 2, 'h000C, 1, 0, 0,      0,    0, 0, 0, 0,       0, 0, 0, 0, 0,     0, 0});
        vt.push_back('{0, 0, 0,      0, 1, 'h000A, 'h11, 0, 0, 0, 0,       0, 0, 0, 0, 0,     0, 1});
        vt.push_back('{0, 0, 0,      0, 1, 'h000B, 'h22, 0, 0, 0, 0,       0, 0, 0, 0, 0,     0, 2});
        vt.push_back('{0, 0, 0,      0, 1, 'h000C, 'h33, 0, 0, 0, 0,       1, 1, 0, 0, 0,     2, 3});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 0, 0,       1, 1, 0, 0, 0,     2, 3});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 1, 'h000D,  1, 1, 1, 1, 'h0D,  2, 3});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 0, 0,       1, 1, 0, 0, 'h0D,  2, 3});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 1, 0, 0,       1, 0, 0, 0, 'h0D,  2, 3});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 0, 0,       0, 0, 0, 0, 'h0D,  2, 3});
        vt.push_back('{0, 0, 0,      0, 1, 'h000D, 'h44, 0, 0, 0, 0,       1, 1, 0, 0, 'h0D,  2, 4});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    1, 0, 0, 0,       1, 0, 0, 0, 'h0D,  2, 4});
        vt.push_back('{0, 0, 0,      0, 1, 'h000C, 'h33, 0, 0, 0, 0,       0, 0, 0, 0, 'h0D,  2, 5});
        vt.push_back('{0, 0, 0,      0, 1, 'h000C, 'h33, 0, 0, 0, 0,       1, 1, 0, 0, 'h0D,  2, 6});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    1, 0, 0, 0,       1, 0, 0, 0, 'h0D,  2, 6});
        vt.push_back('{0, 0, 0,      0, 1, 'h000C, 'h33, 0, 0, 0, 0,       0, 0, 0, 0, 'h0D,  2, 7});
        vt.push_back('{0, 0, 0,      0, 1, 'h000C, 'h33, 0, 0, 0, 0,       1, 1, 0, 0, 'h0D,  2, 8});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 1, 1, 'h0042,  1, 1, 1, 1, 'h42,  2, 8});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 1, 'h0043,  1, 1, 0, 0, 'h42,  2, 8});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 1, 'h0043,  1, 1, 1, 1, 'h43,  2, 8});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 0, 0, 0,       1, 1, 0, 0, 'h43,  2, 8});
        vt.push_back('{1, 0, 'h0100, 1, 0, 0,      0,    0, 0, 0, 0,       1, 1, 0, 0, 'h43,  2, 8});
        vt.push_back('{1, 3, 'h0100, 1, 0, 0,      0,    0, 0, 0, 0,       1, 1, 0, 0, 'h43,  2, 8});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    1, 0, 0, 0,       1, 0, 0, 0, 'h43,  2, 8});
        vt.push_back('{0, 0, 0,      0, 1, 'h0100, 'h55, 0, 0, 1, 'h0077,  0, 0, 0, 0, 'h43,  2, 9});
        vt.push_back('{0, 0, 0,      0, 1, 'h0100, 'h66, 0, 0, 0, 0,       1, 1, 0, 0, 'h43,  0, 10});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    0, 1, 0, 0,       1, 0, 0, 0, 'h43,  0, 10});
        vt.push_back('{0, 0, 0,      0, 1, 'h0100, 'h67, 0, 0, 0, 0,       1, 1, 0, 0, 'h43,  0, 11});
        vt.push_back('{0, 0, 0,      0, 0, 0,      0,    1, 0, 0, 0,       1, 0, 0, 0, 'h43,  0, 11});
        vt.push_back('{0, 0, 0,      0, 1, 'h0200, 'h77, 0, 0, 0, 0,       0, 0, 0, 0, 'h43,  0, 12});
        vt.push_back('{1, 1, 'h0300, 1, 1, 'h0300, 'h78, 0, 0, 0, 0,       0, 0, 0, 0, 'h43,  0, 13});
        vt.push_back('{0, 0, 0,      0, 1, 'h0300, 'h79, 0, 0, 0, 0,       1, 1, 0, 0, 'h43,  1, 14});

        foreach (vt[r]) begin
            drive(vt[r].bpw, vt[r].bpi, vt[r].bpa, vt[r].bpv, vt[r].fe, vt[r].pc, vt[r].op,
                  vt[r].res, vt[r].stp, vt[r].req, vt[r].val);
            @(negedge clk);
            chk($sformatf("row%0d cpu_halt", r), int'(bus.cpu_halt), vt[r].e_halt);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d halted", r), int'(bus.halted), vt[r].e_halted);
            chk($sformatf("row%0d pc_ld", r), int'(bus.pc_ld), vt[r].e_ld);
            chk($sformatf("row%0d ack", r), int'(bus.dbg_pc_ack), vt[r].e_ack);
            chk($sformatf("row%0d pc_new", r), int'(bus.pc_new), vt[r].e_pcnew);
            chk($sformatf("row%0d hit_idx", r), int'(bus.hit_idx), vt[r].e_hit);
            chk($sformatf("row%0d trace_count", r), int'(bus.trace_count), vt[r].e_cnt);
        end
        idle();

        // Trace readback after the directed table, including the empty-slot boundary
        bus.trace_rd_idx = 4'd0;
        #1 chk("tr0 pc", int'(bus.trace_rd_pc), 'h0300);
        chk("tr0 op", int'(bus.trace_rd_op), 'h79);
        bus.trace_rd_idx = 4'd1;
        #1 chk("tr1 op", int'(bus.trace_rd_op), 'h78);
        bus.trace_rd_idx = 4'd13;
        #1 chk("tr13 pc", int'(bus.trace_rd_pc), 'h000A);
        chk("tr13 op", int'(bus.trace_rd_op), 'h11);
        bus.trace_rd_idx = 4'd14;
        #1 chk("tr14 empty pc", int'(bus.trace_rd_pc), 0);
        chk("tr14 empty op", int'(bus.trace_rd_op), 0);
        bus.trace_rd_idx = 4'd0;
        @(posedge clk);
        #1;

        // Async reset in the middle of an injection
        do_reset();
        drive(1, 2, 'h000C, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 'h000C, 'h33, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h000D);
        @(posedge clk); #1;
        chk("inj pc_ld", int'(bus.pc_ld), 1);
        idle();
        rst = 1'b1;
        #1;
        chk("arst pc_ld", int'(bus.pc_ld), 0);
        chk("arst ack", int'(bus.dbg_pc_ack), 0);
        chk("arst cpu_halt", int'(bus.cpu_halt), 0);
        chk("arst halted", int'(bus.halted), 0);
        chk("arst trace_count", int'(bus.trace_count), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 'h000C, 'h33, 0, 0, 0, 0);
        @(negedge clk);
        chk("arst slot cleared", int'(bus.cpu_halt), 0);
        @(posedge clk); #1;
        idle();
        chk("arst count after fetch", int'(bus.trace_count), 1);
        chk("arst not halted", int'(bus.halted), 0);

        // Trace wrap: 20 fetches into 16 entries
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 1, i, 'h80 + i, 0, 0, 0, 0);
            @(posedge clk); #1;
            if (i == 2) begin
                idle();
                bus.trace_rd_idx = 4'd2;
                #1 chk("wrap3 idx2 op", int'(bus.trace_rd_op), 'h80);
                bus.trace_rd_idx = 4'd3;
                #1 chk("wrap3 idx3 op", int'(bus.trace_rd_op), 0);
                bus.trace_rd_idx = 4'd0;
            end
        end
        idle();
        chk("wrap count", int'(bus.trace_count), 16);
        #1 chk("wrap idx0 pc", int'(bus.trace_rd_pc), 19);
        bus.trace_rd_idx = 4'd15;
        #1 chk("wrap idx15 pc", int'(bus.trace_rd_pc), 4);
        chk("wrap idx15 op", int'(bus.trace_rd_op), 'h84);
        bus.trace_rd_idx = 4'd0;
        @(posedge clk); #1;

        // Randomized run against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            tent_t e;
            int    ri;
            drive(($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(0, 65535)));
            ri = int'($urandom_range(0, 15));
            bus.trace_rd_idx = 4'(ri);
            e = '{0, 0};
            if (ri < m_tr.size()) e = m_tr[ri];
            @(negedge clk);
            chk($sformatf("rnd%0d cpu_halt", c), int'(bus.cpu_halt), m_halt());
            chk($sformatf("rnd%0d trace pc", c), int'(bus.trace_rd_pc), e.pc);
            chk($sformatf("rnd%0d trace op", c), int'(bus.trace_rd_op), e.op);
            m_commit();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d halted", c), int'(bus.halted), int'(mm == M_HALT || mm == M_INJ));
            chk($sformatf("rnd%0d pc_ld", c), int'(bus.pc_ld), int'(mm == M_INJ));
            chk($sformatf("rnd%0d ack", c), int'(bus.dbg_pc_ack), int'(mm == M_INJ));
            chk($sformatf("rnd%0d pc_new", c), int'(bus.pc_new), m_pcnew);
            chk($sformatf("rnd%0d hit_idx", c), int'(bus.hit_idx), m_hit);
            chk($sformatf("rnd%0d trace_count", c), int'(bus.trace_count), m_tr.size());
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gb_debug_unit.md
Name: gb_debug_unit

Overview:
- Synthesizable CPU debug controller for the de10boy core.
- Replaces bench-only forcing of the CPU's PC_new/PC_ld with real hardware: parametrised PC breakpoints, halt/step/resume control, and a handshaked PC-injection path.
- Keeps a circular trace of recently fetched PC/opcode pairs.
- Sits beside the cpu instance in the top level and drives the CPU's PC_new/PC_ld and stall inputs.

Parameters:
- ADDR_W, 16, PC/breakpoint address width
- NUM_BP, 4, number of breakpoint comparators (1..16)
- TRACE_DEPTH, 16, trace entries; power of two, 2..256

Ports:
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_pc  in  ADDR_W  PC of the current fetch
- cpu_fetch  in  1  one-cycle pulse: opcode fetch at cpu_pc
- cpu_opcode  in  8  fetched opcode, valid with cpu_fetch
- bp_wr_en  in  1  write breakpoint slot
- bp_wr_idx  in  $clog2(NUM_BP)  slot index
- bp_wr_addr  in  ADDR_W  breakpoint address
- bp_wr_valid  in  1  slot enable value to write
- dbg_resume  in  1  leave HALT, run freely
- dbg_step  in  1  leave HALT for exactly one fetch
- dbg_pc_req  in  1  level request to load dbg_pc_val into PC
- dbg_pc_val  in  ADDR_W  PC value to inject
- dbg_pc_ack  out  1  one-cycle acknowledge of injection
- pc_new  out  ADDR_W  to CPU PC_new
- pc_ld  out  1  to CPU PC_ld
- cpu_halt  out  1  CPU stall
- halted  out  1  registered: state is HALT or INJECT
- hit_idx  out  $clog2(NUM_BP)  slot that caused last breakpoint halt
- trace_rd_idx  in  $clog2(TRACE_DEPTH)  0 = most recent entry
- trace_rd_pc  out  ADDR_W  traced PC
- trace_rd_op  out  8  traced opcode
- trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries, saturating

Behaviour:
- Reset (async): state RUN; all slots invalid; trace write pointer 0; trace_count 0; skip 0; every output 0.
- Asserting reset mid-inject drops pc_ld and dbg_pc_ack immediately.
- States: RUN, HALT, STEP, INJECT.
- match = cpu_fetch & any valid slot with addr == cpu_pc & ~skip. On multiple hits, the lowest index wins.
- RUN:
  - cpu_halt = match, combinational, so the matching instruction stalls in the same cycle.
  - On match: next state HALT; hit_idx registered.
  - Any fetch clears skip.
- HALT: cpu_halt = 1. Priority is dbg_pc_req > dbg_step > dbg_resume.
  - dbg_pc_req -> INJECT.
  - dbg_step -> STEP.
  - dbg_resume -> RUN with skip = 1, so the halted PC does not re-trigger.
- INJECT (one cycle):
  - pc_new = dbg_pc_val, pc_ld = 1, dbg_pc_ack = 1, cpu_halt = 1.
  - Next state HALT.
  - If dbg_pc_req is still high next cycle, a new injection occurs; the requester must drop it on ack.
- STEP:
  - cpu_halt = 0 until the first cpu_fetch.
  - That fetch is traced, breakpoints are ignored, and cpu_halt = 1 in the same cycle; next state HALT.
- dbg_pc_req in RUN/STEP: ignored; no ack. It is serviced once HALT is reached if still asserted.
- pc_new holds its last value; pc_ld is 1 only in INJECT.
- Trace:
  - Every cpu_fetch is written at the write pointer, including a matching or stepped fetch, but not while in HALT.
  - The pointer wraps modulo TRACE_DEPTH; trace_count saturates at TRACE_DEPTH.
  - Read is combinational: entry (wr_ptr-1-trace_rd_idx) mod depth.
  - If trace_rd_idx >= trace_count, outputs are 0.
- Breakpoint writes are accepted in any state. A write coincident with a fetch: the match uses the pre-write table.

Decomposition:
- Package gb_debug_pkg: dbg_state_t enum (RUN, HALT, STEP, INJECT), trace_entry_t struct {pc, opcode}, default widths.
- Sub-module gb_trace_buffer: circular RAM, write pointer, count, indexed read.

Test Plan:
- Breakpoint halt: slot 2 = 16'h000C valid; fetches at 000A, 000B, 000C -> cpu_halt=1 in the 000C fetch cycle, halted=1 next cycle, hit_idx=2, trace_count=3.
- Injection: halted; dbg_pc_req=1, dbg_pc_val=16'h000D -> next cycle pc_ld=1, pc_new=000D, ack=1 for exactly one cycle; state returns to HALT.
- Step then resume: step -> exactly one fetch traced, re-halt. Resume at breakpoint PC 000C -> no immediate re-halt; the next fetch of 000C halts again.
- Overlap and priority: slots 0 and 3 both 0x0100 -> hit_idx=0. dbg_pc_req and dbg_step same cycle in HALT -> INJECT first.
- Trace wrap: TRACE_DEPTH=16, 20 fetches PC 0..19 -> trace_count=16, idx0=19, idx15=4.
- Async reset mid-INJECT -> pc_ld, ack, cpu_halt=0 immediately; slots cleared; trace_count=0.
